// File: rtl/msk_data_unloader.sv
// ============================================================================
// msk_data_unloader
// Takes one captured d-share masked value and streams it unmasked as 32-bit words.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module msk_data_unloader #(
  parameter int D    = 2,
  parameter int BITS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [D*BITS-1:0] sh_data_in,
  input  logic              in_mode_256,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OUT   = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [2:0] C_BOUND_256 = 3'd7;
  localparam logic [2:0] C_BOUND_128 = 3'd3;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [BITS-1:0]   share_q [D];
  logic [BITS-1:0]   share_d [D];

  logic [2:0]        w_bound;
  logic [31:0]       w_word;
  logic              w_out_state;
  logic              w_beat;

  assign w_bound     = mode_q ? C_BOUND_256 : C_BOUND_128;
  assign w_out_state = (state_q == S_OUT) && !rst;
  assign w_beat      = w_out_state && out_ready;

  // Shares meet only here, one word wide, and only while the word is on the bus.
  always_comb begin
    w_word = '0;
    for (int s = 0; s < D; s++) begin
      w_word = w_word ^ share_q[s][31:0];
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = w_out_state;
  assign data_out  = w_out_state ? w_word : 32'h0;
  assign out_last  = w_out_state && (cnt_q == w_bound);
  assign busy      = (state_q != S_IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    share_d = share_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Un-interleave the shared bus; bits above 128 are dropped in 128-bit mode.
          for (int s = 0; s < D; s++) begin
            for (int b = 0; b < BITS; b++) begin
              share_d[s][b] = (in_mode_256 || (b < 128)) ? sh_data_in[b*D+s] : 1'b0;
            end
          end
          mode_d  = in_mode_256;
          cnt_d   = 3'd0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          for (int s = 0; s < D; s++) begin
            share_d[s] = share_q[s] >> 32;
          end
          if (cnt_q == w_bound) begin
            state_d = S_CLEAR;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_CLEAR: begin
        for (int s = 0; s < D; s++) begin
          share_d[s] = '0;
        end
        cnt_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      mode_q  <= 1'b0;
      for (int s = 0; s < D; s++) begin
        share_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      for (int s = 0; s < D; s++) begin
        share_q[s] <= share_d[s];
      end
    end
  end

  // w_beat documents the acceptance condition used by the next-state logic.
  logic w_unused;
  assign w_unused = w_beat;

endmodule

`default_nettype wire

// File: tb/tb_msk_data_unloader.sv
// ============================================================================
// tb_msk_data_unloader
// Scoreboard bench: stimulus pushes expected beats, a monitor pops and compares.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_msk_data_unloader;

  localparam int D    = 3;
  localparam int BITS = 256;

  logic              clk;
  logic              rst;
  logic [D*BITS-1:0] sh_data_in;
  logic              in_mode_256;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       data_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [32:0] exp_q [$];

  msk_data_unloader #(.D(D), .BITS(BITS)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .sh_data_in  (sh_data_in),
    .in_mode_256 (in_mode_256),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  // Monitor: every presented beat must match the scoreboard head; pop on acceptance.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_beat: got %h, required no beat", data_out);
      end else begin
        chk("beat_data", {32'h0, data_out}, {32'h0, exp_q[0][31:0]});
        chk("beat_last", {63'h0, out_last}, {63'h0, exp_q[0][32]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_data_zero", {32'h0, data_out}, 64'h0);
      chk("idle_last_zero", {63'h0, out_last}, 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic make_bus(input logic [255:0] v, output logic [D*BITS-1:0] bus);
    logic [255:0] sh [D];
    logic [255:0] acc;
    acc = v;
    for (int s = 0; s < D-1; s++) begin
      for (int k = 0; k < 8; k++) sh[s][32*k +: 32] = $urandom;
      acc = acc ^ sh[s];
    end
    sh[D-1] = acc;
    bus = '0;
    for (int b = 0; b < 256; b++)
      for (int s = 0; s < D; s++)
        bus[b*D+s] = sh[s][b];
  endtask

  task automatic push_words(input logic [255:0] v, input logic mode, input int n);
    int nw;
    nw = mode ? 8 : 4;
    for (int w = 0; w < n; w++) exp_q.push_back({(w == nw-1), v[32*w +: 32]});
  endtask

  task automatic capture(input logic [255:0] v, input logic mode);
    logic [D*BITS-1:0] bus;
    make_bus(v, bus);
    sh_data_in  = bus;
    in_mode_256 = mode;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    sh_data_in  = '1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!in_ready && i < 100) begin
      tick();
      i++;
    end
    chk("idle_timeout", {63'h0, in_ready}, 64'h1);
  endtask

  task automatic check_zeroized(input string nm);
    for (int s = 0; s < D; s++) chk(nm, {63'h0, |u_dut.share_q[s]}, 64'h0);
  endtask

  logic [255:0] v_a, v_b, v_c;
  logic [6:0]   bp_pat;
  logic [D*BITS-1:0] bus_b;

  initial begin
    v_a    = {128'h0, 128'h00112233_44556677_8899aabb_ccddeeff};
    v_b    = {128'h0, 128'hdeadbeef_0badf00d_13572468_a5a55a5a};
    v_c    = 256'hfedcba98_76543210_01234567_89abcdef_c0ffee00_11112222_33334444_55556666;
    bp_pat = 7'b1101001;  // LSB first: 1,0,0,1,0,1,1

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sh_data_in = '0; in_mode_256 = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    check_zeroized("rst_share_zero");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Basic 128-bit transfer with exact timing.
    out_ready = 1'b1;
    push_words(v_a, 1'b0, 4);
    capture(v_a, 1'b0);
    tick(); tick(); tick(); tick();
    chk("clear_in_ready", {63'h0, in_ready}, 64'h0);
    chk("clear_busy", {63'h0, busy}, 64'h1);
    chk("clear_out_valid", {63'h0, out_valid}, 64'h0);
    tick();
    chk("ret_in_ready", {63'h0, in_ready}, 64'h1);
    chk("ret_busy", {63'h0, busy}, 64'h0);
    check_zeroized("basic_share_zero");
    chk("basic_queue_empty", exp_q.size(), 64'h0);

    // Backpressure.
    out_ready = 1'b0;
    push_words(v_a, 1'b0, 4);
    capture(v_a, 1'b0);
    for (int i = 0; i < 7; i++) begin
      out_ready = bp_pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    chk("bp_queue_empty", exp_q.size(), 64'h0);

    // 256-bit mode.
    for (int i = 0; i < 8; i++) v_c[32*i +: 32] = 32'h1000_0000 + i;
    push_words(v_c, 1'b1, 8);
    capture(v_c, 1'b1);
    wait_idle();
    check_zeroized("m256_share_zero");
    chk("m256_queue_empty", exp_q.size(), 64'h0);

    // Capture blocking: in_valid held through OUT with another value on the bus.
    push_words(v_a, 1'b0, 4);
    push_words(v_b, 1'b0, 4);
    make_bus(v_b, bus_b);
    in_valid = 1'b1;
    capture(v_a, 1'b0);
    in_valid    = 1'b1;
    in_mode_256 = 1'b0;
    sh_data_in  = bus_b;
    for (int i = 0; i < 5; i++) begin
      chk("block_in_ready", {63'h0, in_ready}, 64'h0);
      tick();
    end
    chk("block_first_idle", {63'h0, in_ready}, 64'h1);
    tick();
    in_valid   = 1'b0;
    sh_data_in = '0;
    chk("block_captured", {63'h0, busy}, 64'h1);
    wait_idle();
    chk("block_queue_empty", exp_q.size(), 64'h0);

    // Reset after beat 2.
    out_ready = 1'b1;
    push_words(v_a, 1'b0, 2);
    capture(v_a, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("mrst_data_out", {32'h0, data_out}, 64'h0);
    chk("mrst_busy", {63'h0, busy}, 64'h0);
    check_zeroized("mrst_share_zero");
    rst = 1'b0;
    tick();
    chk("mrst_queue_empty", exp_q.size(), 64'h0);
    v_c = 256'hfedcba98_76543210_01234567_89abcdef_c0ffee00_11112222_33334444_55556666;
    push_words(v_c, 1'b1, 8);
    capture(v_c, 1'b1);
    wait_idle();
    check_zeroized("fresh_share_zero");
    chk("fresh_queue_empty", exp_q.size(), 64'h0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/msk_data_unloader.md
Name: msk_data_unloader

Overview:
- Output-side counterpart of the masked key/data loader.
- Accepts one d-share masked value from the core: 128 bits, or 256 bits in 256-bit mode. The value is in shared-bus encoding.
- Streams the unmasked value out as 32-bit words over a valid/ready bus, least-significant word first.
- Shares are recombined only one word at a time, at the output. Storage is zeroized after the last beat.

Parameters:
- d, 2, number of shares (≥2).
- BITS, 256, maximum data width per share; fixed.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sh_data_in  in  d*BITS  shared-bus value; bit b of share s at index b*d+s. In 128-bit mode only bits b<128 are used.
- in_mode_256  in  1  sampled with the capture handshake; 1 = 8 words, 0 = 4 words.
- in_valid  in  1  input valid.
- in_ready  out  1  input ready.
- data_out  out  32  unmasked word.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- out_last  out  1  high on the final word of a transfer.
- busy  out  1  high whenever state≠IDLE.

Behaviour:
- Reset values: state=IDLE, word counter=0, cfg_mode_256=0, share storage all-zero. During rst: in_ready=0, out_valid=0, out_last=0, data_out=0, busy=0.
- Capture handshake: in_ready=1 in IDLE (and ~rst). A capture happens when in_valid&in_ready at a rising edge. The capture:
  - decodes the shared bus into d per-share registers of BITS bits;
  - latches in_mode_256 into cfg_mode_256;
  - clears the word counter;
  - moves to OUT.
- Capture-to-output latency: out_valid rises the cycle after capture.
- OUT state:
  - out_valid=1, in_ready=0.
  - data_out = XOR over s of share_s[31:0]. Each share register is consumed as a right-shifting register, 32 bits per beat.
  - A beat is accepted when out_valid&out_ready. On acceptance: every share register shifts right by 32 with zero fill, and the counter increments.
- Backpressure: while out_ready=0, data_out, out_last and all storage hold.
- out_last=1 in OUT when counter = bound, where bound = 7 if cfg_mode_256 else 3. Acceptance of the last beat moves to CLEAR.
- CLEAR state (1 cycle):
  - all share registers and the counter are written to 0;
  - out_valid=0, in_ready=0, busy=1;
  - next state is IDLE.
- data_out is forced to 32'h0 whenever out_valid=0. Recombined data is never exposed outside OUT.
- in_valid is ignored outside IDLE; no capture and no state change.
- sh_data_in may change freely after the capture cycle; only the captured copy is used.
- Word order: word w = bits [32w+31:32w] of the unmasked value.
- Reset mid-transfer: at the next edge the state returns to IDLE and storage is zeroed. No further beats are emitted, even if out_ready is high.
- Counter is 3 bits and never wraps past bound; the exit to CLEAR happens at bound.
- Share registers are updated only on capture, accepted beat, CLEAR or reset. No glitching recombination paths feed the registers back.

Test Plan:
- Basic 128-bit transfer (d=2):
  - Stimulus: value V=128'h00112233_44556677_8899aabb_ccddeeff; share0=R=random 128 bits, share1=R^V; in_mode_256=0; out_ready=1.
  - Required: beats ccddeeff, 8899aabb, 44556677, 00112233 on consecutive cycles starting one cycle after capture; out_last on beat 4; one CLEAR cycle; in_ready returns 2 cycles after beat 4.
- Backpressure:
  - Stimulus: same value; out_ready toggles 1,0,0,1,0,1,1.
  - Required: each word held stable while stalled; exactly 4 accepted beats in order; no duplication.
- 256-bit mode (d=3):
  - Stimulus: in_mode_256=1; value words 0..7 = 32'h1000_0000+i; three random sharings.
  - Required: 8 beats equal to 1000_0000..1000_0007; out_last only on the 8th.
- Capture blocking:
  - Stimulus: in_valid held high during OUT with a different sh_data_in.
  - Required: in_ready=0; the output stream is unaffected; the new value is captured only in the first IDLE cycle after CLEAR.
- Reset mid-transfer:
  - Stimulus: assert rst after beat 2 is accepted, with out_ready=1.
  - Required: out_valid=0 and data_out=0 from the next cycle; share storage reads 0 (hierarchical check); a fresh capture after reset produces correct words starting at word 0.
- Zeroization:
  - Stimulus: after any complete transfer.
  - Required: all share registers are 0 in the cycle after CLEAR, and data_out=0 while idle.
